// File: rtl/bpi_seq_ctrl.sv
// Autonomous BPI command sequencer: replays a preloaded command buffer into the
// engine's command FIFO, then drains a programmed number of readback words.
module bpi_seq_ctrl #(
  parameter int          DEPTH   = 16,
  parameter int          AW      = 4,
  parameter logic [23:0] TMO_CYC = 24'd4000000
) (
  input  logic          CLK,
  input  logic          RST_B,
  input  logic          LD_CLR,
  input  logic          LD_WE,
  input  logic [15:0]   LD_DATA,
  output logic [AW:0]   LD_CNT,
  output logic          LD_OVF,
  input  logic          START,
  input  logic          ABORT,
  input  logic [10:0]   RBK_EXP,
  output logic          BUSY,
  output logic          DONE,
  output logic          TMO_ERR,
  output logic [15:0]   RBK_DATA,
  output logic          RBK_VALID,
  output logic          BPI_RST,
  output logic          BPI_DSBL,
  output logic          BPI_ENBL,
  output logic          BPI_WE,
  output logic          BPI_RE,
  output logic [15:0]   BPI_CMD_FIFO_DATA,
  input  logic          BPI_CMD_FULL,
  input  logic [15:0]   BPI_RBK_FIFO_DATA,
  input  logic [10:0]   BPI_RBK_WRD_CNT
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DSBL,
    S_WRITE,
    S_ENBL,
    S_WAIT,
    S_READ,
    S_GAP,
    S_TMO,
    S_FIN
  } state_e;

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [23:0] TMO_LAST  = TMO_CYC - 24'd1;

  state_e      state_q, state_d;
  logic [15:0] cmd_mem_q [DEPTH];
  logic [AW:0] ld_cnt_q, ld_cnt_d;
  logic [AW:0] idx_q, idx_d;
  logic        ld_ovf_q, ld_ovf_d;
  logic [10:0] rem_q, rem_d;
  logic [23:0] timer_q, timer_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tmo_err_q, tmo_err_d;
  logic [15:0] rbk_data_q, rbk_data_d;
  logic        rbk_valid_q, rbk_valid_d;
  logic        rst_q, rst_d;
  logic        dsbl_q, dsbl_d;
  logic        enbl_q, enbl_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic [15:0] cmd_data_q, cmd_data_d;
  logic        mem_we;
  logic        abort_run;

  // Every pulse is registered on the edge that enters the state owning it,
  // so a pulse is visible for exactly the cycle that state is active.
  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    ld_ovf_d    = ld_ovf_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    timer_d     = timer_q;
    busy_d      = busy_q;
    tmo_err_d   = tmo_err_q;
    rbk_data_d  = rbk_data_q;
    cmd_data_d  = cmd_data_q;
    done_d      = 1'b0;
    rbk_valid_d = 1'b0;
    rst_d       = 1'b0;
    dsbl_d      = 1'b0;
    enbl_d      = 1'b0;
    we_d        = 1'b0;
    re_d        = 1'b0;
    mem_we      = 1'b0;
    abort_run   = ABORT && !(state_q inside {S_IDLE, S_TMO, S_FIN});

    if (LD_CLR) begin
      ld_cnt_d = '0;
      ld_ovf_d = 1'b0;
    end else if (LD_WE) begin
      if (state_q == S_IDLE && ld_cnt_q < DEPTH_CNT) begin
        mem_we   = 1'b1;
        ld_cnt_d = ld_cnt_q + 1'b1;
      end else begin
        ld_ovf_d = 1'b1;
      end
    end

    if (abort_run) begin
      state_d   = S_TMO;
      rst_d     = 1'b1;
      tmo_err_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_d   = S_DSBL;
            dsbl_d    = 1'b1;
            busy_d    = 1'b1;
            tmo_err_d = 1'b0;
            rem_d     = RBK_EXP;
            idx_d     = '0;
          end
        end
        // idx counts words already issued; >= guards against a mid-run LD_CLR.
        S_DSBL, S_WRITE: begin
          if (idx_q >= ld_cnt_q) begin
            state_d = S_ENBL;
            enbl_d  = 1'b1;
            timer_d = '0;
          end else begin
            state_d = S_WRITE;
            if (!BPI_CMD_FULL) begin
              we_d       = 1'b1;
              cmd_data_d = cmd_mem_q[idx_q[AW-1:0]];
              idx_d      = idx_q + 1'b1;
            end
          end
        end
        S_ENBL: begin
          state_d = S_WAIT;
          timer_d = '0;
        end
        S_WAIT: begin
          if (rem_q == 11'd0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (BPI_RBK_WRD_CNT != 11'd0) begin
            state_d = S_READ;
            re_d    = 1'b1;
          end else if (timer_q >= TMO_LAST) begin
            state_d   = S_TMO;
            rst_d     = 1'b1;
            tmo_err_d = 1'b1;
          end else begin
            timer_d = timer_q + 24'd1;
          end
        end
        // The FIFO is first-word-fall-through, so the head is the word being popped.
        S_READ: begin
          state_d     = S_GAP;
          rbk_data_d  = BPI_RBK_FIFO_DATA;
          rbk_valid_d = 1'b1;
          rem_d       = rem_q - 11'd1;
          timer_d     = '0;
        end
        S_GAP: state_d = S_WAIT;
        S_TMO: begin
          state_d = S_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q     <= S_IDLE;
      ld_cnt_q    <= '0;
      ld_ovf_q    <= 1'b0;
      idx_q       <= '0;
      rem_q       <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
      rbk_data_q  <= '0;
      rbk_valid_q <= 1'b0;
      rst_q       <= 1'b0;
      dsbl_q      <= 1'b0;
      enbl_q      <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      cmd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      ld_ovf_q    <= ld_ovf_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tmo_err_q   <= tmo_err_d;
      rbk_data_q  <= rbk_data_d;
      rbk_valid_q <= rbk_valid_d;
      rst_q       <= rst_d;
      dsbl_q      <= dsbl_d;
      enbl_q      <= enbl_d;
      we_q        <= we_d;
      re_q        <= re_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

  // Buffer contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      cmd_mem_q[ld_cnt_q[AW-1:0]] <= LD_DATA;
    end
  end

  assign LD_CNT            = ld_cnt_q;
  assign LD_OVF            = ld_ovf_q;
  assign BUSY              = busy_q;
  assign DONE              = done_q;
  assign TMO_ERR           = tmo_err_q;
  assign RBK_DATA          = rbk_data_q;
  assign RBK_VALID         = rbk_valid_q;
  assign BPI_RST           = rst_q;
  assign BPI_DSBL          = dsbl_q;
  assign BPI_ENBL          = enbl_q;
  assign BPI_WE            = we_q;
  assign BPI_RE            = re_q;
  assign BPI_CMD_FIFO_DATA = cmd_data_q;

endmodule
